// File: rtl/sdr_chunk_reader.sv
// Job-level read sequencer: splits a word job into CHUNK-word bridge reads and streams the words out.
// Optional overlap of the next read with draining is enabled by defining SDR_CHUNK_PREFETCH_EN.
module sdr_chunk_reader #(
  parameter int CHUNK = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           job_addr,
  input  logic [29:0]           job_nwords,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           sdr_baseaddr,
  output logic [29:0]           sdr_nelems,
  output logic                  sdr_readstart,
  input  logic                  sdr_readend,
  input  logic [32*CHUNK-1:0]   sdr_readdata,
  output logic [31:0]           out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam int          CW      = $clog2(CHUNK + 1);
  localparam int          IW      = (CHUNK > 1) ? $clog2(CHUNK) : 1;
  localparam logic [29:0] CHUNK_W = 30'(CHUNK);
  localparam logic [31:0] STRIDE  = 32'(4 * CHUNK);

`ifdef SDR_CHUNK_PREFETCH_EN
  localparam bit PREFETCH = 1'b1;
`else
  localparam bit PREFETCH = 1'b0;
`endif

  typedef enum logic [1:0] {F_IDLE, F_ISSUE, F_WAIT, F_HOLD} f_state_t;

  f_state_t        f_state_q, f_state_d, after_capture;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [31:0]     base_q, base_d;
  logic [29:0]     nelems_q, nelems_d;
  logic [31:0]     fetch_addr_q, fetch_addr_d;
  logic [29:0]     remaining_q, remaining_d;
  logic [29:0]     out_left_q, out_left_d;
  logic            buf_full_q, buf_full_d;
  logic [CW-1:0]   buf_count_q, buf_count_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [31:0]     buf_q [CHUNK];
  logic [31:0]     buf_d [CHUNK];

  logic            accept, capture, handshake, chunk_end, issue_enter;
  logic [31:0]     src_addr;
  logic [29:0]     src_rem, chunk_len;

  assign accept    = start && !busy_q;
  assign handshake = buf_full_q && out_ready;
  assign chunk_end = handshake && (CW'(idx_q) == buf_count_q - CW'(1));
  assign after_capture = (PREFETCH && remaining_q != '0) ? F_ISSUE : F_IDLE;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      f_state_q    <= F_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      base_q       <= '0;
      nelems_q     <= '0;
      fetch_addr_q <= '0;
      remaining_q  <= '0;
      out_left_q   <= '0;
      buf_full_q   <= 1'b0;
      buf_count_q  <= '0;
      idx_q        <= '0;
    end else begin
      f_state_q    <= f_state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      base_q       <= base_d;
      nelems_q     <= nelems_d;
      fetch_addr_q <= fetch_addr_d;
      remaining_q  <= remaining_d;
      out_left_q   <= out_left_d;
      buf_full_q   <= buf_full_d;
      buf_count_q  <= buf_count_d;
      idx_q        <= idx_d;
    end
  end

  // Buffer contents need no reset: they are only visible while buf_full_q is set.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  generate
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_buf
      assign buf_d[gi] = capture ? sdr_readdata[32*gi +: 32] : buf_q[gi];
    end
  endgenerate

  // Fetch FSM next state
  always_comb begin
    f_state_d = f_state_q;
    capture   = 1'b0;
    unique case (f_state_q)
      F_IDLE: begin
        if (accept && job_nwords != '0) begin
          f_state_d = F_ISSUE;
        end else if (busy_q && remaining_q != '0 && !buf_full_q) begin
          f_state_d = F_ISSUE;
        end
      end
      F_ISSUE: f_state_d = F_WAIT;
      F_WAIT: begin
        if (sdr_readend) begin
          if (!buf_full_q) begin
            capture   = 1'b1;
            f_state_d = after_capture;
          end else begin
            f_state_d = F_HOLD;
          end
        end
      end
      F_HOLD: begin
        if (!buf_full_q) begin
          capture   = 1'b1;
          f_state_d = after_capture;
        end
      end
      default: f_state_d = F_IDLE;
    endcase
  end

  assign issue_enter = (f_state_d == F_ISSUE) && (f_state_q != F_ISSUE);
  assign src_addr    = accept ? job_addr : fetch_addr_q;
  assign src_rem     = accept ? job_nwords : remaining_q;
  assign chunk_len   = (src_rem > CHUNK_W) ? CHUNK_W : src_rem;

  always_comb begin
    busy_d       = busy_q;
    base_d       = base_q;
    nelems_d     = nelems_q;
    fetch_addr_d = fetch_addr_q;
    remaining_d  = remaining_q;
    out_left_d   = out_left_q;
    buf_full_d   = buf_full_q;
    buf_count_d  = buf_count_q;
    idx_d        = idx_q;
    done_d       = (accept && job_nwords == '0) || (handshake && out_last);

    if (accept) begin
      busy_d       = 1'b1;
      out_left_d   = job_nwords;
      fetch_addr_d = job_addr;
      remaining_d  = job_nwords;
    end
    if (done_q) begin
      busy_d = 1'b0;
    end
    // Chunk parameters are frozen on entry to F_ISSUE and held through F_WAIT/F_HOLD.
    if (issue_enter) begin
      base_d       = src_addr;
      nelems_d     = chunk_len;
      fetch_addr_d = src_addr + STRIDE;
      remaining_d  = src_rem - chunk_len;
    end
    if (handshake) begin
      idx_d      = idx_q + 1'b1;
      out_left_d = out_left_q - 30'd1;
    end
    if (chunk_end) begin
      buf_full_d = 1'b0;
      idx_d      = '0;
    end
    if (capture) begin
      buf_full_d  = 1'b1;
      buf_count_d = CW'(nelems_q);
      idx_d       = '0;
    end
  end

  // Outputs
  always_comb begin
    busy          = busy_q;
    done          = done_q;
    sdr_readstart = (f_state_q == F_ISSUE);
    sdr_baseaddr  = base_q;
    sdr_nelems    = nelems_q;
    out_valid     = buf_full_q;
    out_last      = buf_full_q && (out_left_q == 30'd1);
    out_data      = buf_full_q ? buf_q[idx_q] : '0;
  end

endmodule

// File: tb/tb_sdr_chunk_reader.sv
// Directed bench for sdr_chunk_reader with a behavioural bridge model and address-derived data.
// Read-issue ordering check adapts to SDR_CHUNK_PREFETCH_EN.
module tb_sdr_chunk_reader;

  localparam int CHUNK = 64;

  logic                clk;
  logic                reset;
  logic                start;
  logic [31:0]         job_addr;
  logic [29:0]         job_nwords;
  logic                busy, done;
  logic [31:0]         sdr_baseaddr;
  logic [29:0]         sdr_nelems;
  logic                sdr_readstart;
  logic                sdr_readend;
  logic [32*CHUNK-1:0] sdr_readdata;
  logic [31:0]         out_data;
  logic                out_valid, out_ready, out_last;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int br_lat;
  bit stale_req;

  logic [31:0] rs_addr [$];
  logic [29:0] rs_n [$];
  int          rs_cyc [$];

  sdr_chunk_reader #(.CHUNK(CHUNK)) dut (
    .clk(clk), .reset(reset), .start(start), .job_addr(job_addr), .job_nwords(job_nwords),
    .busy(busy), .done(done), .sdr_baseaddr(sdr_baseaddr), .sdr_nelems(sdr_nelems),
    .sdr_readstart(sdr_readstart), .sdr_readend(sdr_readend), .sdr_readdata(sdr_readdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
  endfunction

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Bridge model: answers each read after br_lat cycles, keeps the bus stable, drops work on reset.
  initial begin : bridge
    logic [31:0] bb;
    logic [29:0] bn;
    bit ok, fresh;
    sdr_readend  = 1'b0;
    sdr_readdata = '0;
    fresh = 1'b0;
    forever begin
      if (!fresh) @(negedge clk);
      fresh = 1'b0;
      if (stale_req) begin
        for (int i = 0; i < CHUNK; i++) sdr_readdata[32*i +: 32] = 32'hBAD0_0000 | 32'(i);
        sdr_readend = 1'b1;
        @(negedge clk);
        sdr_readend = 1'b0;
        stale_req = 1'b0;
        fresh = 1'b1;
      end else if (reset && sdr_readstart) begin
        bb = sdr_baseaddr;
        bn = sdr_nelems;
        rs_addr.push_back(bb);
        rs_n.push_back(bn);
        rs_cyc.push_back(cyc);
        $display("read  base=0x%08h nelems=%0d cycle=%0d", bb, bn, cyc);
        ok = 1'b1;
        for (int k = 0; k < br_lat; k++) begin
          @(negedge clk);
          if (!reset) ok = 1'b0;
        end
        if (ok) begin
          for (int i = 0; i < CHUNK; i++)
            sdr_readdata[32*i +: 32] = (i < int'(bn)) ? pat(bb + 32'(4*i)) : (32'hDEAD_0000 | 32'(i));
          sdr_readend = 1'b1;
          @(negedge clk);
          sdr_readend = 1'b0;
        end
        fresh = 1'b1;
      end
    end
  end

  task automatic check_all_zero(input string ctx);
    check_value({ctx, "_busy"},      32'(busy),          32'd0);
    check_value({ctx, "_done"},      32'(done),          32'd0);
    check_value({ctx, "_readstart"}, 32'(sdr_readstart), 32'd0);
    check_value({ctx, "_baseaddr"},  sdr_baseaddr,       32'd0);
    check_value({ctx, "_nelems"},    32'(sdr_nelems),    32'd0);
    check_value({ctx, "_valid"},     32'(out_valid),     32'd0);
    check_value({ctx, "_last"},      32'(out_last),      32'd0);
    check_value({ctx, "_data"},      out_data,           32'd0);
  endtask

  task automatic run_job(input logic [31:0] a, input logic [29:0] n, input bit rnd, input int abort_at);
    int j, t, nreads, hs63, e;
    logic [31:0] pd;
    logic pl, stall, rdy;
    rs_addr.delete(); rs_n.delete(); rs_cyc.delete();
    job_addr = a; job_nwords = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_value("busy_on_accept", 32'(busy), 32'd1);
    if (n == 0) begin
      check_value("zero_done", 32'(done), 32'd1);
      check_value("zero_readstart", 32'(sdr_readstart), 32'd0);
      @(negedge clk);
      check_value("zero_done_clear", 32'(done), 32'd0);
      check_value("zero_busy_clear", 32'(busy), 32'd0);
      check_value("zero_reads", 32'(rs_addr.size()), 32'd0);
      $display("job   addr=0x%08h nwords=0 -> done, no read", a);
      return;
    end
    e = (int'(n) > CHUNK) ? CHUNK : int'(n);
    check_value("issue_readstart", 32'(sdr_readstart), 32'd1);
    check_value("issue_baseaddr", sdr_baseaddr, a);
    check_value("issue_nelems", 32'(sdr_nelems), 32'(e));
    j = 0; t = 0; stall = 1'b0; hs63 = -1; pd = '0; pl = 1'b0;
    while (j < int'(n) && t < 5000) begin
      if (j == abort_at) begin
        reset = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check_all_zero("midjob_reset");
        @(negedge clk);
        reset = 1'b1;
        $display("job   addr=0x%08h nwords=%0d aborted by reset after %0d words", a, n, j);
        return;
      end
      if (stall) begin
        check_value("stall_valid", 32'(out_valid), 32'd1);
        check_value("stall_data", out_data, pd);
        check_value("stall_last", 32'(out_last), 32'(pl));
      end
      rdy = rnd ? ($urandom_range(1, 0) == 1) : 1'b1;
      out_ready = rdy;
      if (out_valid && rdy) begin
        check_value("word_data", out_data, pat(a + 32'(4*j)));
        check_value("word_last", 32'(out_last), 32'(j == int'(n) - 1));
        if (j == 63) hs63 = cyc;
        j++;
        stall = 1'b0;
      end else begin
        stall = out_valid; pd = out_data; pl = out_last;
      end
      @(negedge clk);
      t++;
    end
    out_ready = 1'b0;
    check_value("words_out", 32'(j), 32'(n));
    check_value("done_pulse", 32'(done), 32'd1);
    check_value("valid_after_last", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_value("done_clear", 32'(done), 32'd0);
    check_value("busy_clear", 32'(busy), 32'd0);
    nreads = (int'(n) + CHUNK - 1) / CHUNK;
    check_value("read_count", 32'(rs_addr.size()), 32'(nreads));
    for (int k = 0; k < nreads && k < rs_addr.size(); k++) begin
      e = int'(n) - CHUNK*k;
      if (e > CHUNK) e = CHUNK;
      check_value("read_addr", rs_addr[k], a + 32'(4*CHUNK*k));
      check_value("read_nelems", 32'(rs_n[k]), 32'(e));
    end
    if (int'(n) > CHUNK && rs_cyc.size() > 1) begin
`ifdef SDR_CHUNK_PREFETCH_EN
      check_value("prefetch_before_drain", 32'(rs_cyc[1] < hs63), 32'd1);
`else
      check_value("issue_after_drain", 32'(rs_cyc[1] > hs63), 32'd1);
`endif
    end
    $display("job   addr=0x%08h nwords=%0d words=%0d reads=%0d", a, n, j, rs_addr.size());
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; out_ready = 1'b0;
    job_addr = '0; job_nwords = '0; stale_req = 1'b0; br_lat = 3;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    run_job(32'h0000_1000, 30'd5,   1'b0, -1);
    run_job(32'h0000_1000, 30'd130, 1'b0, -1);
    run_job(32'h0000_5000, 30'd0,   1'b0, -1);
    br_lat = 2;
    run_job(32'h0000_4000, 30'd70,  1'b1, -1);
    run_job(32'hFFFF_FF00, 30'd128, 1'b0, -1);
    br_lat = 3;
    run_job(32'h0000_2000, 30'd130, 1'b0, 66);

    stale_req = 1'b1;
    repeat (5) @(negedge clk);
    check_value("stale_readend_valid", 32'(out_valid), 32'd0);
    check_value("stale_readend_busy", 32'(busy), 32'd0);
    run_job(32'h0000_3000, 30'd10, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
